// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - lsop encodings driven by the decode stage through EX/MEM
//   - FSM state encoding (also exported on the debug state output)
//   - ZeroWord and small op-class helpers
package mem_lsu_pkg;

  localparam logic [3:0] LSOP_NONE = 4'd0;
  localparam logic [3:0] LSOP_LB   = 4'd1;
  localparam logic [3:0] LSOP_LBU  = 4'd2;
  localparam logic [3:0] LSOP_LH   = 4'd3;
  localparam logic [3:0] LSOP_LHU  = 4'd4;
  localparam logic [3:0] LSOP_LW   = 4'd5;
  localparam logic [3:0] LSOP_SB   = 4'd6;
  localparam logic [3:0] LSOP_SH   = 4'd7;
  localparam logic [3:0] LSOP_SW   = 4'd8;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= LSOP_LB) && (op <= LSOP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= LSOP_SB) && (op <= LSOP_SW);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: purely combinational big-endian lane logic.
//   lsop_i        load/store op code
//   addr_lo_i     effective address bits [1:0]
//   store_data_i  rt value for stores
//   rdata_i       raw bus read word
//   sel_o         byte enables (bit 3 = bits [31:24]); zero for loads
//   wdata_o       store data replicated across lanes
//   load_data_o   extracted and sign/zero-extended load value
//   misaligned_o  halfword/word access not on its natural boundary
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]  lsop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    // Lane 0 is the most significant byte.
    case (addr_lo_i)
      2'b00:   rbyte = rdata_i[31:24];
      2'b01:   rbyte = rdata_i[23:16];
      2'b10:   rbyte = rdata_i[15:8];
      default: rbyte = rdata_i[7:0];
    endcase
    rhalf = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  always_comb begin
    sel_o        = 4'b0000;
    wdata_o      = ZeroWord;
    load_data_o  = ZeroWord;
    misaligned_o = 1'b0;
    case (lsop_i)
      LSOP_LB:  load_data_o = {{24{rbyte[7]}}, rbyte};
      LSOP_LBU: load_data_o = {24'h000000, rbyte};
      LSOP_LH: begin
        misaligned_o = addr_lo_i[0];
        load_data_o  = {{16{rhalf[15]}}, rhalf};
      end
      LSOP_LHU: begin
        misaligned_o = addr_lo_i[0];
        load_data_o  = {16'h0000, rhalf};
      end
      LSOP_LW: begin
        misaligned_o = |addr_lo_i;
        load_data_o  = rdata_i;
      end
      LSOP_SB: begin
        sel_o   = 4'b1000 >> addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      LSOP_SH: begin
        misaligned_o = addr_lo_i[0];
        sel_o        = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wdata_o      = {2{store_data_i[15:0]}};
      end
      LSOP_SW: begin
        misaligned_o = |addr_lo_i;
        sel_o        = 4'b1111;
        wdata_o      = store_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM pipeline stage with load/store unit.
//   Non-memory ops pass wd/wreg/wdata and HI/LO straight to MEM/WB.
//   Memory ops run IDLE -> WAIT (bus request until mem_ack_i) -> DONE,
//   holding stallreq_o high through IDLE and WAIT so EX/MEM stays stable.
// Ports:
//   clk, rst (synchronous, active-high; forces every output to 0)
//   wd_i/wreg_i/wdata_i/hi_i/lo_i/whilo_i  from EX/MEM
//   lsop_i, mem_addr_i, store_data_i       memory op description
//   mem_req_o/mem_we_o/mem_addr_o/mem_sel_o/mem_wdata_o, mem_rdata_i, mem_ack_i  data bus
//     Handshake: the request is held with stable address/data while mem_req_o=1;
//     the transfer completes in the cycle mem_ack_i=1 is sampled with mem_req_o=1.
//     mem_ack_i seen with no request outstanding is ignored.
//   wd_o/wreg_o/wdata_o/hi_o/lo_o/whilo_o  to MEM/WB
//   stallreq_o, align_exc_o, bus_err_o, state_o (debug view of the FSM)
// Build option: define MEM_LSU_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC
//   cycles without ack (bus_err_o pulses in the DONE cycle).
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [31:0]           hi_i,
  input  logic [31:0]           lo_i,
  input  logic                  whilo_i,
  input  logic [3:0]            lsop_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           store_data_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [3:0]            mem_sel_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  whilo_o,
  output logic                  stallreq_o,
  output logic                  align_exc_o,
  output logic                  bus_err_o,
  output lsu_state_e            state_o
);

  lsu_state_e  state_q, state_d;
  logic [31:0] load_q, load_d;
  logic [3:0]  sel;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        misaligned;
  logic        op_load, op_store, op_mem;
  logic        timeout_hit;
  logic        bus_err_now;

  lsu_align u_align (
    .lsop_i       (lsop_i),
    .addr_lo_i    (mem_addr_i[1:0]),
    .store_data_i (store_data_i),
    .rdata_i      (mem_rdata_i),
    .sel_o        (sel),
    .wdata_o      (st_wdata),
    .load_data_o  (ld_data),
    .misaligned_o (misaligned)
  );

  assign op_load  = is_load(lsop_i);
  assign op_store = is_store(lsop_i);
  assign op_mem   = op_load | op_store;

`ifdef MEM_LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  // The counter reads k during the (k+1)-th WAIT cycle, so matching
  // TIMEOUT_CYC-1 gives exactly TIMEOUT_CYC WAIT cycles before the abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
    err_d = (state_q == ST_WAIT) && !mem_ack_i && timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus_err_now = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err_now = 1'b0;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      load_q  <= ZeroWord;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    case (state_q)
      ST_IDLE: if (op_mem && !misaligned) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_ack_i) begin
          load_d  = ld_data;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    hi_o        = hi_i;
    lo_o        = lo_i;
    whilo_o     = whilo_i;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_sel_o   = 4'b0000;
    mem_wdata_o = ZeroWord;
    stallreq_o  = 1'b0;
    align_exc_o = 1'b0;
    bus_err_o   = 1'b0;
    state_o     = state_q;
    case (state_q)
      ST_IDLE: begin
        if (op_mem) begin
          wreg_o = 1'b0;
          if (misaligned) align_exc_o = 1'b1;
          else            stallreq_o  = 1'b1;
        end
      end
      ST_WAIT: begin
        wreg_o      = 1'b0;
        mem_req_o   = 1'b1;
        mem_we_o    = op_store;
        mem_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};
        mem_sel_o   = sel;
        mem_wdata_o = st_wdata;
        stallreq_o  = 1'b1;
      end
      ST_DONE: begin
        // A timed-out load discards its data and never writes back.
        wreg_o    = wreg_i & op_load & ~bus_err_now;
        bus_err_o = bus_err_now;
        if (op_load) wdata_o = load_q;
      end
      default: ;
    endcase
    if (rst) begin
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = ZeroWord;
      hi_o        = ZeroWord;
      lo_o        = ZeroWord;
      whilo_o     = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_sel_o   = 4'b0000;
      mem_wdata_o = ZeroWord;
      stallreq_o  = 1'b0;
      align_exc_o = 1'b0;
      bus_err_o   = 1'b0;
      state_o     = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized scoreboard bench for mem_lsu.
`timescale 1ns/1ps
module tb_mem_lsu;
  import mem_lsu_pkg::*;

`ifdef MEM_LSU_TIMEOUT_EN
  localparam int TCYC = 4;
`else
  localparam int TCYC = 255;
`endif
  localparam int MAX_DELAY = (TCYC > 5) ? 5 : TCYC - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, hi_i, lo_i;
  logic        whilo_i;
  logic [3:0]  lsop_i;
  logic [31:0] mem_addr_i, store_data_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o, hi_o, lo_o;
  logic        whilo_o, stallreq_o, align_exc_o, bus_err_o;
  lsu_state_e  state_o;

  mem_lsu #(.REG_ADDR_W(5), .ADDR_W(32), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
    .lsop_i(lsop_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .stallreq_o(stallreq_o), .align_exc_o(align_exc_o), .bus_err_o(bus_err_o), .state_o(state_o)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        wreg;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic        aexc;
    logic        berr;
    logic [7:0]  stalls;
  } wb_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_t;
  localparam int WB_W  = $bits(wb_t);
  localparam int BUS_W = $bits(bus_t);

  logic [WB_W-1:0]  exp_q[$];
  logic [BUS_W-1:0] bus_q[$];
  int tests = 0;
  int fails = 0;
  logic instr_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      LSOP_LB, LSOP_LBU, LSOP_SB: return 1;
      LSOP_LH, LSOP_LHU, LSOP_SH: return 2;
      LSOP_LW, LSOP_SW:           return 4;
      default:                    return 0;
    endcase
  endfunction

  // Shift the addressed bytes to the top of the word, then down to the bottom.
  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [1:0] off, input logic [31:0] rd);
    int sz;
    logic [31:0] top, val;
    sz  = op_size(op);
    top = rd << (8 * int'(off));
    val = top >> (8 * (4 - sz));
    if ((op == LSOP_LB || op == LSOP_LH) && top[31]) val = val | (32'hFFFF_FFFF << (8 * sz));
    return val;
  endfunction

  function automatic logic [3:0] model_sel(input int sz, input logic [1:0] off);
    return 4'(((1 << sz) - 1) << (4 - int'(off) - sz));
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] sd);
    logic [31:0] mask, w;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    w = '0;
    for (int i = 0; i < 4 / sz; i++) w = w | ((sd & mask) << (8 * sz * i));
    return w;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] rd, input int delay, input logic [4:0] wd,
                       input logic wreg, input logic [31:0] wdata, input logic [31:0] hi,
                       input logic [31:0] lo, input logic whilo);
    wb_t  e;
    bus_t b;
    int   sz, waited, budget;
    logic mis, ld, st, tmo;
    @(posedge clk); #1;
    lsop_i = op; mem_addr_i = addr; store_data_i = sd; wd_i = wd; wreg_i = wreg;
    wdata_i = wdata; hi_i = hi; lo_i = lo; whilo_i = whilo; mem_ack_i = 1'b0;
    instr_v = 1'b1;

    sz  = op_size(op);
    ld  = (op == LSOP_LB || op == LSOP_LBU || op == LSOP_LH || op == LSOP_LHU || op == LSOP_LW);
    st  = (op == LSOP_SB || op == LSOP_SH || op == LSOP_SW);
    mis = (sz > 0) && ((int'(addr[1:0]) % sz) != 0);
    tmo = (delay >= TCYC);
    e.wd = wd; e.hi = hi; e.lo = lo; e.whilo = whilo;
    e.aexc = mis; e.berr = 1'b0; e.wdata = wdata; e.stalls = 8'd0; e.wreg = wreg;
    if (sz > 0) begin
      e.wreg = 1'b0;
      if (!mis) begin
        e.stalls = tmo ? 8'(1 + TCYC) : 8'(2 + delay);
        e.berr   = tmo;
        if (ld && !tmo) begin
          e.wreg  = wreg;
          e.wdata = model_load(op, addr[1:0], rd);
        end
        b.we    = st;
        b.addr  = {addr[31:2], 2'b00};
        b.sel   = st ? model_sel(sz, addr[1:0]) : 4'b0000;
        b.wdata = st ? model_wdata(sz, sd) : 32'h0;
        bus_q.push_back(b);
      end
    end
    exp_q.push_back(e);

    // Bus responder: ack after `delay` request cycles; run until the op retires.
    #1;
    waited = 0;
    budget = 0;
    while (stallreq_o) begin
      if (mem_req_o) begin
        if (waited == delay) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = rd;
        end
        waited++;
      end
      @(posedge clk); #1;
      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
      #1;
      budget++;
      if (budget > TCYC + 20) begin
        tests++;
        fails++;
        $display("FAIL retire_timeout: op %0d still stalled after %0d cycles", op, budget);
        break;
      end
    end
    @(negedge clk); #1;
    instr_v = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    wb_t  e;
    bus_t b;
    int   stalls;
    logic req_prev;
    stalls   = 0;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && instr_v) begin
        if (mem_req_o && !req_prev) begin
          if (bus_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL bus_unexpected: mem_req_o=1 with no memory op pending at %0t", $time);
          end else begin
            b = bus_q.pop_front();
            check("bus_we", 32'(mem_we_o), 32'(b.we));
            check("bus_addr", mem_addr_o, b.addr);
            if (b.we) begin
              check("bus_sel", 32'(mem_sel_o), 32'(b.sel));
              check("bus_wdata", mem_wdata_o, b.wdata);
            end
          end
        end
        req_prev = mem_req_o;
        if (stallreq_o) begin
          stalls++;
        end else begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL wb_unexpected: retire with empty expected queue at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("wb_wreg", 32'(wreg_o), 32'(e.wreg));
            if (e.wreg) check("wb_wdata", wdata_o, e.wdata);
            check("wb_wd", 32'(wd_o), 32'(e.wd));
            check("wb_hi", hi_o, e.hi);
            check("wb_lo", lo_o, e.lo);
            check("wb_whilo", 32'(whilo_o), 32'(e.whilo));
            check("wb_align_exc", 32'(align_exc_o), 32'(e.aexc));
            check("wb_bus_err", 32'(bus_err_o), 32'(e.berr));
            check("wb_stall_cycles", 32'(stalls), 32'(e.stalls));
          end
          stalls = 0;
        end
      end else begin
        stalls   = 0;
        req_prev = 1'b0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic check_outputs_zero(input string tag);
    check({tag, "_wdata"}, wdata_o, 32'h0);
    check({tag, "_hi"}, hi_o, 32'h0);
    check({tag, "_lo"}, lo_o, 32'h0);
    check({tag, "_ctrl"},
          32'({wd_o, wreg_o, whilo_o, mem_req_o, mem_we_o, mem_sel_o, stallreq_o, align_exc_o, bus_err_o}),
          32'h0);
    check({tag, "_bus"}, mem_addr_o | mem_wdata_o, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF; hi_i = 32'h1111_2222; lo_i = 32'h3333_4444;
    whilo_i = 1'b1; lsop_i = LSOP_NONE; mem_addr_i = 32'h0; store_data_i = 32'h0;
    mem_rdata_i = 32'h0; mem_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    check("reset_state", 32'(state_o), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    issue(LSOP_NONE, 32'h0, 32'h0, 32'h0, 0, 5'd3, 1'b1, 32'h0000_1234, 32'hA, 32'hB, 1'b1);
    issue(LSOP_LB,  32'h101, 32'h0, 32'h11F0_2233, 0, 5'd4, 1'b1, 32'h5, 32'h0, 32'h0, 1'b0);
    issue(LSOP_LBU, 32'h101, 32'h0, 32'h11F0_2233, 0, 5'd4, 1'b1, 32'h5, 32'h0, 32'h0, 1'b0);
    issue(LSOP_SH,  32'h202, 32'hAAAA_5678, 32'h0, 0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    issue(LSOP_LW,  32'h301, 32'h0, 32'h0, 0, 5'd9, 1'b1, 32'h77, 32'h0, 32'h0, 1'b0);
    issue(LSOP_LH,  32'h402, 32'h0, 32'h1234_8001, 2, 5'd1, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
    issue(LSOP_SW,  32'h500, 32'hCAFE_F00D, 32'h0, 1, 5'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Randomized traffic, including back-to-back memory ops
    for (int n = 0; n < 80; n++) begin
      issue(4'($urandom_range(0, 8)), $urandom, $urandom, $urandom, $urandom_range(0, MAX_DELAY),
            5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
    end

`ifdef MEM_LSU_TIMEOUT_EN
    // No ack at all: abort after TCYC WAIT cycles
    issue(LSOP_LW, 32'h600, 32'h0, 32'h0, 1000, 5'd6, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #2;
    check("timeout_back_to_idle", 32'(state_o), 32'(ST_IDLE));
`endif

    // Reset during a delayed-ack load
    @(posedge clk); #1;
    lsop_i = LSOP_LW; mem_addr_i = 32'h700; wreg_i = 1'b1; wd_i = 5'd12;
    wdata_i = 32'h55; hi_i = 32'h66; lo_i = 32'h77; whilo_i = 1'b1; mem_ack_i = 1'b0;
    #1;
    check("rstwait_idle_stall", 32'(stallreq_o), 32'h1);
    repeat (3) begin
      @(posedge clk); #2;
      check("rstwait_stall", 32'(stallreq_o), 32'h1);
      check("rstwait_req", 32'(mem_req_o), 32'h1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_in_wait");
    @(posedge clk); #1;
    rst = 1'b0;
    lsop_i = LSOP_NONE; mem_addr_i = 32'h0; wreg_i = 1'b0; wd_i = 5'd0; wdata_i = 32'h0;
    hi_i = 32'h0; lo_i = 32'h0; whilo_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h9999_9999;
    #1;
    check("post_rst_state", 32'(state_o), 32'(ST_IDLE));
    check_outputs_zero("post_rst");
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    #1;
    check("late_ack_state", 32'(state_o), 32'(ST_IDLE));
    check("late_ack_wreg", 32'(wreg_o), 32'h0);
    check("late_ack_wdata", wdata_o, 32'h0);

    // Pipeline keeps working after the reset
    issue(LSOP_LHU, 32'h802, 32'h0, 32'h0102_F3F4, 0, 5'd5, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    issue(LSOP_SB,  32'h903, 32'h0000_00AB, 32'h0, 3, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("bus_q_drained", 32'(bus_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
MEM pipeline stage, second generation; sits between the EX/MEM and MEM/WB pipeline registers.
- Non-memory instructions pass the write-back info (wd/wreg/wdata, HI/LO) straight through, as in the first-generation stage.
- Load/store instructions are handled here: a req/ack data-bus handshake, big-endian byte-lane generation, load extraction with sign/zero extension, alignment checking, and a stall request held while the bus is busy.

Parameters:
- REG_ADDR_W, 5, width of register-file address.
- ADDR_W, 32, data-bus address width.
- TIMEOUT_CYC, 255, bus-wait cycle limit; used only with MEM_LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- wd_i  in  REG_ADDR_W  destination register.
- wreg_i  in  1  register write enable.
- wdata_i  in  32  ALU result.
- hi_i, lo_i  in  32 each  HI/LO write values.
- whilo_i  in  1  HI/LO write enable.
- lsop_i  in  4  load/store op code (package constants).
- mem_addr_i  in  ADDR_W  effective address.
- store_data_i  in  32  rt value for stores.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  ADDR_W  word-aligned address (low 2 bits forced 0).
- mem_sel_o  out  4  byte enables; bit 3 = bits [31:24].
- mem_wdata_o  out  32  store data.
- mem_rdata_i  in  32  read data.
- mem_ack_i  in  1  bus completion.
- wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o  out  same widths as inputs  to MEM/WB.
- stallreq_o  out  1  stall request to pipeline control.
- align_exc_o  out  1  misaligned access.
- bus_err_o  out  1  bus timeout.

Behaviour:
- Reset: rst synchronous, active-high. On reset:
  - FSM goes to IDLE; captured load data is cleared.
  - While rst=1 all outputs are forced to 0, including hi_o, lo_o and whilo_o, which the first generation did not reset.
- Op codes: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- Alignment:
  - LH/LHU/SH: misaligned if addr[0]=1.
  - LW/SW: misaligned if addr[1:0]!=0.
  - Misaligned access: no bus request, align_exc_o=1 (combinational), wreg_o=0, stallreq_o=0, FSM stays IDLE.
- Store lanes (big-endian):
  - SB: sel = 4'b1000 >> addr[1:0]; wdata = byte replicated to all 4 lanes.
  - SH: addr[1]=0 gives sel 4'b1100, else 4'b0011; wdata = halfword replicated.
  - SW: sel 4'b1111.
- Load extract:
  - LB/LBU: byte at lane addr[1:0] (00 = [31:24]).
  - LH/LHU: addr[1]=0 gives [31:16], else [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, lsop=NONE: combinational passthrough, zero latency, stallreq_o=0.
  - IDLE, aligned memory op: stallreq_o=1 combinationally; next state WAIT.
  - WAIT: mem_req_o=1, bus outputs driven from the inputs (the pipeline holds EX/MEM stable while stalled), stallreq_o=1.
    - On mem_ack_i: register the extracted load data, then go to DONE.
    - mem_ack_i sampled in IDLE or DONE is ignored.
  - DONE: mem_req_o=0, stallreq_o=0.
    - Loads: wdata_o = captured data, wreg_o = wreg_i.
    - Stores: wreg_o=0.
    - Next state IDLE; the pipeline advances this cycle.
- Latency: minimum 3 cycles per memory op (ack in the first WAIT cycle); each extra WAIT cycle adds one.
- Simultaneous events:
  - rst overrides ack: a pending request is dropped and no write-back occurs.
  - Back-to-back memory ops: DONE→IDLE→WAIT; no bubble-free chaining.
- hi_o/lo_o/whilo_o always pass through when not in reset.

Optional Feature:
- MEM_LSU_TIMEOUT_EN defined:
  - An 8+-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When the counter reaches TIMEOUT_CYC: go to DONE with bus_err_o=1 for that DONE cycle, wreg_o=0, load data discarded.
- Not defined: no counter, bus_err_o tied 0, WAIT lasts indefinitely.

Decomposition:
- Package mem_lsu_pkg holds:
  - lsop encodings (NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8);
  - FSM state encodings;
  - ZeroWord.
- One combinational sub-module, lsu_align: computes sel, store data, load extract/extend and the misaligned flag from lsop, addr[1:0], store data and read data.

Test Plan:
- lsop=NONE, wdata_i=0x1234, wreg_i=1, whilo_i=1 → same cycle: wdata_o=0x1234, wreg_o=1, whilo_o=1, stallreq_o=0, mem_req_o=0.
- LB, addr=0x101, rdata=0x11F02233, ack in first WAIT cycle:
  - mem_addr_o=0x100, stallreq_o high for 2 cycles;
  - DONE: wdata_o=0xFFFFFFF0.
  - Same sequence with LBU → 0x000000F0.
- SH, addr=0x202, store_data_i=0xAAAA5678 → mem_we_o=1, sel=4'b0011, wdata=0x56785678; DONE: wreg_o=0.
- LW, addr=0x301 → align_exc_o=1, mem_req_o never asserted, wreg_o=0, stallreq_o=0.
- LW with ack delayed 5 cycles, then rst pulsed during WAIT → stallreq_o held until reset; after reset: FSM IDLE, all outputs 0, late ack ignored.
- With MEM_LSU_TIMEOUT_EN and TIMEOUT_CYC=4, no ack → exactly 4 WAIT cycles, then DONE with bus_err_o=1, wreg_o=0; back in IDLE the next cycle.
